// File: rtl/mem_controller.sv
// Round-robin arbiter between NUM_CONSUMERS LSUs and one external data-memory port.
// One memory transaction in flight; read data and acknowledges return to the granted LSU.

module mem_controller_lane #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout
);
  always_ff @(posedge clk or negedge reset)
    if (!reset)    dout <= '0;
    else if (load) dout <= din;
endmodule

module mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);
  localparam int ID_W = $clog2(NUM_CONSUMERS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CONSUMERS - 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  typedef struct packed {
    logic                 rd;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } mem_req_t;

  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] rd_addr, wr_addr;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] wr_data, rd_data;
  logic [NUM_CONSUMERS-1:0]                req_any, rd_load;

  state_t          state, state_nx;
  mem_req_t        req_q, req_nx;
  logic [ID_W-1:0] grant_id, grant_nx, rr_ptr, rr_nx, pick_id, scan_id;
  logic            pick_vld, pick_rd, owner_vld;
  logic            mrv_nx, mwv_nx;
  logic [NUM_CONSUMERS-1:0] crr_nx, cwr_nx;
  int              scan;

  assign rd_addr            = consumer_read_address;
  assign wr_addr            = consumer_write_address;
  assign wr_data            = consumer_write_data;
  assign consumer_read_data = rd_data;
  assign req_any            = consumer_read_valid | consumer_write_valid;

  // The single request register feeds both memory channels; only one valid is ever high.
  assign mem_read_address  = req_q.addr;
  assign mem_write_address = req_q.addr;
  assign mem_write_data    = req_q.data;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan     = 0;
    scan_id  = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_CONSUMERS) scan = scan - NUM_CONSUMERS;
      scan_id = ID_W'(scan);
      if (!pick_vld && req_any[scan_id]) begin
        pick_vld = 1'b1;
        pick_id  = scan_id;
      end
    end
  end

  assign pick_rd   = consumer_read_valid[pick_id];
  assign owner_vld = req_q.rd ? consumer_read_valid[grant_id] : consumer_write_valid[grant_id];

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (pick_vld)        state_nx = pick_rd ? READ_WAIT : WRITE_WAIT;
      READ_WAIT:  if (mem_read_ready)  state_nx = RELAY;
      WRITE_WAIT: if (mem_write_ready) state_nx = RELAY;
      RELAY:      if (!owner_vld)      state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant_nx = grant_id;
    rr_nx    = rr_ptr;
    req_nx   = req_q;
    mrv_nx   = mem_read_valid;
    mwv_nx   = mem_write_valid;
    crr_nx   = consumer_read_ready;
    cwr_nx   = consumer_write_ready;
    rd_load  = '0;
    case (state)
      IDLE: if (pick_vld) begin
        grant_nx    = pick_id;
        rr_nx       = (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
        req_nx.rd   = pick_rd;
        req_nx.addr = pick_rd ? rd_addr[pick_id] : wr_addr[pick_id];
        req_nx.data = pick_rd ? req_q.data : wr_data[pick_id];
        mrv_nx      = pick_rd;
        mwv_nx      = !pick_rd;
      end
      READ_WAIT: if (mem_read_ready) begin
        mrv_nx            = 1'b0;
        crr_nx[grant_id]  = 1'b1;
        rd_load[grant_id] = 1'b1;
      end
      WRITE_WAIT: if (mem_write_ready) begin
        mwv_nx           = 1'b0;
        cwr_nx[grant_id] = 1'b1;
      end
      RELAY: if (!owner_vld) begin
        crr_nx = '0;
        cwr_nx = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      grant_id             <= '0;
      rr_ptr               <= '0;
      req_q                <= '0;
      mem_read_valid       <= 1'b0;
      mem_write_valid      <= 1'b0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
    end else begin
      grant_id             <= grant_nx;
      rr_ptr               <= rr_nx;
      req_q                <= req_nx;
      mem_read_valid       <= mrv_nx;
      mem_write_valid      <= mwv_nx;
      consumer_read_ready  <= crr_nx;
      consumer_write_ready <= cwr_nx;
    end

  for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_lane
    mem_controller_lane #(.DATA_BITS(DATA_BITS)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (rd_load[i]),
      .din   (mem_read_data),
      .dout  (rd_data[i])
    );
  end
endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: directed scenarios plus randomized LSU/memory traffic
// checked every cycle against a transaction-level reference model.
module tb_mem_controller;
  localparam int NC = 4, AB = 8, DB = 8;
  localparam int IW = $clog2(NC);
  typedef logic [IW-1:0] id_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [NC-1:0] rv = '0, wv = '0, crr, cwr;
  logic [NC-1:0][AB-1:0] raddr = '0, waddr = '0;
  logic [NC-1:0][DB-1:0] wdat = '0, crd;
  logic mrv, mwv, mrr = 1'b0, mwr = 1'b0;
  logic [AB-1:0] mra, mwa;
  logic [DB-1:0] mrd = '0, mwd;

  mem_controller #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(raddr),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_address(waddr),
    .consumer_write_data(wdat), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
    .mem_write_ready(mwr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [DB-1:0] mem [256];

  // Reference model: 0 = free, 1 = memory transaction open, 2 = handing result back.
  int phase;
  id_t own, m_rr;
  bit own_rd;
  logic [AB-1:0] e_addr;
  logic [DB-1:0] e_wd;
  logic e_mrv, e_mwv;
  logic [NC-1:0] e_rrdy, e_wrdy, p_crr, p_cwr;
  logic [NC-1:0][DB-1:0] e_rdata;
  int dut_grants[$];
  bit rseen[NC], wseen[NC];
  bit rand_en;
  int stall, stall_set;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sys_reset();
    phase = 0; own = '0; own_rd = 1'b0; m_rr = '0;
    e_addr = '0; e_wd = '0; e_mrv = 1'b0; e_mwv = 1'b0;
    e_rrdy = '0; e_wrdy = '0; e_rdata = '0; p_crr = '0; p_cwr = '0;
    rv = '0; wv = '0; mrr = 1'b0; mwr = 1'b0; stall = stall_set;
    for (int i = 0; i < NC; i++) begin rseen[i] = 1'b0; wseen[i] = 1'b0; end
  endtask

  // Applies the rules to the inputs that were sampled at the edge just taken.
  task automatic model_edge();
    if (!reset) begin sys_reset(); return; end
    case (phase)
      0: for (int k = 0; k < NC; k++) begin
        id_t i;
        i = id_t'((int'(m_rr) + k) % NC);
        if (phase == 0 && (rv[i] || wv[i])) begin
          own = i; own_rd = rv[i];
          e_addr = rv[i] ? raddr[i] : waddr[i];
          if (!rv[i]) e_wd = wdat[i];
          e_mrv = rv[i]; e_mwv = !rv[i];
          m_rr = id_t'((int'(i) + 1) % NC);
          phase = 1;
        end
      end
      1: if (own_rd ? mrr : mwr) begin
        phase = 2; e_mrv = 1'b0; e_mwv = 1'b0;
        if (own_rd) begin e_rdata[own] = mem[e_addr]; e_rrdy[own] = 1'b1; end
        else begin mem[mwa] = mwd; e_wrdy[own] = 1'b1; end
      end
      2: if (!(own_rd ? rv[own] : wv[own])) begin
        phase = 0; e_rrdy = '0; e_wrdy = '0;
      end
      default: phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("mem_read_valid", mrv, e_mrv);
    chk("mem_write_valid", mwv, e_mwv);
    if (e_mrv) chk("mem_read_address", mra, e_addr);
    if (e_mwv) begin
      chk("mem_write_address", mwa, e_addr);
      chk("mem_write_data", mwd, e_wd);
    end
    chk("consumer_read_ready", crr, e_rrdy);
    chk("consumer_write_ready", cwr, e_wrdy);
    chk("consumer_read_data", crd, e_rdata);
    for (int i = 0; i < NC; i++)
      if ((crr[i] && !p_crr[i]) || (cwr[i] && !p_cwr[i])) dut_grants.push_back(i);
    p_crr = crr; p_cwr = cwr;
  endtask

  // LSUs hold valid until served and drop it one cycle after seeing ready; memory answers after `stall`.
  task automatic drive();
    bit own_r, own_w;
    for (int i = 0; i < NC; i++) begin
      own_r = (phase != 0) && (own == id_t'(i)) && own_rd;
      own_w = (phase != 0) && (own == id_t'(i)) && !own_rd;
      if (rv[i]) begin
        if (crr[i]) begin
          if (rseen[i]) begin rv[i] = 1'b0; rseen[i] = 1'b0; end
          else rseen[i] = 1'b1;
        end else if (rand_en && phase == 1 && own_r && $urandom_range(0, 7) == 0) rv[i] = 1'b0;
      end else begin
        rseen[i] = 1'b0;
        if (rand_en && !own_r && $urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1; raddr[i] = AB'($urandom_range(0, 15));
        end
      end
      if (wv[i]) begin
        if (cwr[i]) begin
          if (wseen[i]) begin wv[i] = 1'b0; wseen[i] = 1'b0; end
          else wseen[i] = 1'b1;
        end else if (rand_en && phase == 1 && own_w && $urandom_range(0, 7) == 0) wv[i] = 1'b0;
      end else begin
        wseen[i] = 1'b0;
        if (rand_en && !own_w && $urandom_range(0, 3) == 0) begin
          wv[i] = 1'b1; waddr[i] = AB'($urandom_range(0, 15)); wdat[i] = DB'($urandom);
        end
      end
    end
    if (mrv || mwv) begin
      if (stall > 0) begin stall--; mrr = 1'b0; mwr = 1'b0; end
      else begin mrr = mrv; mwr = mwv; end
    end else begin
      mrr = 1'b0; mwr = 1'b0;
      stall = rand_en ? int'($urandom_range(0, 3)) : stall_set;
    end
    mrd = mrr ? mem[mra] : DB'($urandom);
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    check_outputs();
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_grants(input string tag, input int exp_q[$]);
    chk({tag, "_count"}, dut_grants.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < dut_grants.size(); k++)
      chk(tag, dut_grants[k], exp_q[k]);
  endtask

  int hi;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = DB'($urandom);
    rand_en = 1'b0; stall_set = 0;
    sys_reset();
    #1 reset = 1'b0;
    #1 check_outputs();
    run(2);
    @(negedge clk) reset = 1'b1;

    // single read: consumer 2, addr 0x3C -> 0xA5, one-cycle memory
    mem[8'h3C] = 8'hA5; rv[2] = 1'b1; raddr[2] = 8'h3C;
    run(6);
    chk("single_read_data", crd[2], 8'hA5);

    // single write: consumer 1 writes 0x7E to 0x10
    wv[1] = 1'b1; waddr[1] = 8'h10; wdat[1] = 8'h7E;
    run(6);
    chk("single_write_mem", mem[8'h10], 8'h7E);

    // bring the pointer to 0, then all four request together
    rv[3] = 1'b1; raddr[3] = 8'h01;
    run(6);
    dut_grants.delete();
    for (int i = 0; i < NC; i++) begin rv[i] = 1'b1; raddr[i] = AB'(8'h40 + i); end
    run(24);
    chk_grants("rr_all_four", '{0, 1, 2, 3});

    dut_grants.delete();
    rv[3] = 1'b1; rv[0] = 1'b1;
    run(12);
    chk_grants("rr_wrap", '{0, 3});

    // memory stall of five cycles on consumer 1
    stall_set = 5; stall = 5; hi = 0;
    rv[1] = 1'b1; raddr[1] = 8'h22;
    for (int c = 0; c < 12; c++) begin step(); if (mrv) hi++; end
    chk("stall_valid_cycles", hi, 6);

    // abort: consumer 2 drops valid while its read is in memory; consumer 0 is next
    stall_set = 2; stall = 2; dut_grants.delete();
    rv[2] = 1'b1; raddr[2] = 8'h05; rv[0] = 1'b1; raddr[0] = 8'h06;
    run(1);
    rv[2] = 1'b0; hi = 0;
    for (int c = 0; c < 14; c++) begin step(); if (crr[2]) hi++; end
    chk("abort_pulse_cycles", hi, 1);
    chk_grants("abort_next", '{2, 0});

    // reset during a stalled read, then pointer must restart at 0
    stall_set = 8; stall = 8;
    rv[2] = 1'b1; raddr[2] = 8'h30;
    run(2);
    #2 reset = 1'b0;
    #1 stall_set = 0; sys_reset(); check_outputs();
    #2 reset = 1'b1;
    dut_grants.delete();
    rv[1] = 1'b1; raddr[1] = 8'h31; rv[3] = 1'b1; raddr[3] = 8'h32;
    run(12);
    chk_grants("post_reset_rr", '{1, 3});

    // randomized traffic, then drain
    rand_en = 1'b1;
    run(3000);
    rand_en = 1'b0;
    run(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
